decoder_nto2n: RTL
==================

DECODER_NTO2N -- requirements
Module: decoder_nto2n

Interface
REQ-001 Parameter N, default 3, input code width; legal range 1..6.
REQ-002 Parameter SCAN_DIV, default 4, clock cycles per scan step; legal range 1..65535.
REQ-003 Parameter ACTIVE_LOW, default 0, output polarity; 1 inverts every bit of out.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  block enable; 0 forces IDLE.
REQ-007 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 in  input  N  binary code to decode in direct mode.
REQ-009 in_valid  input  1  qualifies in for one cycle.
REQ-010 out  output  2**N  registered one-hot decode; bit k active when code = k.
REQ-011 out_valid  output  1  one-cycle strobe marking a new out value.
REQ-012 sel  output  N  registered binary index of the active out bit.

Function
REQ-013 States: IDLE, DIRECT, SCAN; the next state is evaluated every cycle.
REQ-014 Inactive value: out all 0s when ACTIVE_LOW=0, all 1s when ACTIVE_LOW=1.
REQ-015 en=0 in any state -> next IDLE; out inactive, out_valid 0, sel 0, divider and scan index cleared.
REQ-016 IDLE, en=1, mode=0 -> DIRECT; IDLE, en=1, mode=1 -> SCAN.
REQ-017 DIRECT, in_valid=1: next cycle out = one-hot(in), sel = in, out_valid = 1; latency exactly 1 cycle.
REQ-018 DIRECT, in_valid=0: out and sel hold; out_valid = 0.
REQ-019 Back-to-back in_valid: each accepted code appears on out one cycle later, with no bubbles.
REQ-020 SCAN: the divider counts 0..SCAN_DIV-1; at terminal count the index increments and the divider returns to 0.
REQ-021 Scan index wraps from 2**N-1 to 0 with no gap cycle.
REQ-022 SCAN: out = one-hot(index), sel = index; out_valid = 1 for one cycle on each index update, including the first.
REQ-023 On entry to SCAN: index = 0 and divider = 0; out = one-hot(0) and out_valid = 1 on the first SCAN cycle.
REQ-024 SCAN_DIV=1: the index advances every cycle and out_valid is held at 1 continuously.
REQ-025 SCAN: in and in_valid are ignored.
REQ-026 Mode change between DIRECT and SCAN takes effect at the next edge.
REQ-026a Leaving SCAN clears the divider and index.
REQ-026b Entering DIRECT holds out until the next in_valid.
REQ-027 Simultaneous en=0 and in_valid=1: en wins; the code is dropped.
REQ-028 All outputs are driven from registers; there is no combinational path from inputs to outputs.

Reset
REQ-029 rst=1 on a rising edge: state IDLE, out inactive, out_valid 0, sel 0, divider 0, index 0.
REQ-030 rst takes priority over en, mode and in_valid.
REQ-030a Reset mid-scan or mid-decode discards all in-flight state.
REQ-031 The first cycle after rst falls is evaluated from IDLE per REQ-016.

Configuration
REQ-032 Macro DECODER_NTO2N_SCAN_EN compiles in the SCAN state, divider and index logic.
REQ-033 With DECODER_NTO2N_SCAN_EN defined: behaviour per REQ-020..REQ-026b.
REQ-034 Without DECODER_NTO2N_SCAN_EN: the mode port remains and is ignored; SCAN is unreachable; IDLE, en=1 -> DIRECT regardless of mode.
REQ-034a Without DECODER_NTO2N_SCAN_EN: no divider or index registers are synthesised.

Verification (N=3, SCAN_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-035 After rst, en=1, mode=0, in=3'b101 with in_valid=1 -> next cycle out=8'b00100000, sel=5, out_valid=1; in_valid=0 the following cycle -> out held, out_valid=0.
REQ-036 Eight consecutive in_valid cycles with in = 0..7 -> out walks 8'h01..8'h80 one cycle later, out_valid continuously 1.
REQ-037 mode=1 with DECODER_NTO2N_SCAN_EN defined -> out=8'h01 first, then advances every 4 cycles.
REQ-037a Continuing REQ-037: out reaches 8'h80, then wraps to 8'h01; out_valid pulses every 4th cycle; in_valid ignored throughout.
REQ-038 rst asserted mid-scan at index 5 -> next cycle out=0, sel=0, out_valid=0.
REQ-038a Continuing REQ-038, after rst falls -> the scan restarts at 8'h01.
REQ-039 ACTIVE_LOW=1, en=0 -> out=8'hFF; in=2 accepted -> out=8'hFB.
REQ-039a ACTIVE_LOW=1, en=0 and in_valid=1 in the same cycle -> code dropped, out stays 8'hFF.

Source files
------------

// File: rtl/decoder_nto2n.sv
// -----------------------------------------------------------------------------
// decoder_nto2n
// Registered N-to-2**N one-hot decoder with an optional auto-scan mode.
//
// In DIRECT mode every qualified input code is decoded onto out one cycle
// later. In SCAN mode (compiled in only when DECODER_NTO2N_SCAN_EN is defined)
// the block walks the one-hot output through every index, advancing once
// every SCAN_DIV clock cycles and wrapping from 2**N-1 back to 0.
//
// Parameters
//   N          input code width (1..6)
//   SCAN_DIV   clock cycles per scan step (1..65535)
//   ACTIVE_LOW 1 inverts every bit of out
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   en         block enable, 0 returns the block to IDLE
//   mode       0 = direct decode, 1 = auto-scan (ignored without the macro)
//   in         binary code to decode in direct mode
//   in_valid   qualifies in for one cycle
//   out        registered one-hot decode
//   out_valid  one-cycle strobe marking a new out value
//   sel        registered binary index of the active out bit
//
// Build option
//   DECODER_NTO2N_SCAN_EN  compiles in the SCAN state, divider and index.
// -----------------------------------------------------------------------------
module decoder_nto2n #(
    parameter int N          = 3,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       in,
    input  logic               in_valid,
    output logic [(1<<N)-1:0]  out,
    output logic               out_valid,
    output logic [N-1:0]       sel
);

    localparam int W = 1 << N;
    localparam logic [W-1:0] OUT_INACTIVE = {W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   out_q, out_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   sel_q, sel_d;

`ifdef DECODER_NTO2N_SCAN_EN
    localparam logic [15:0] DIV_TC = 16'(SCAN_DIV - 1);

    logic [15:0]    div_q, div_d;
    logic [N-1:0]   idx_q, idx_d;
`else
    // mode has no effect when scanning is not built in
    logic           unused_mode;
    assign unused_mode = mode;
`endif

    // One-hot decode with the configured output polarity applied
    function automatic logic [W-1:0] onehot(input logic [N-1:0] code);
        logic [W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return ACTIVE_LOW ? ~v : v;
    endfunction

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sel_d       = sel_q;
`ifdef DECODER_NTO2N_SCAN_EN
        div_d       = div_q;
        idx_d       = idx_q;
`endif
        if (!en) begin
            // Disable wins over everything, including a pending in_valid
            state_d = IDLE;
            out_d   = OUT_INACTIVE;
            sel_d   = '0;
`ifdef DECODER_NTO2N_SCAN_EN
            div_d   = '0;
            idx_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef DECODER_NTO2N_SCAN_EN
                    if (mode) begin
                        // Scan entry presents index 0 on the first SCAN cycle
                        state_d     = SCAN;
                        div_d       = '0;
                        idx_d       = '0;
                        out_d       = onehot('0);
                        sel_d       = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = DIRECT;
                    end
`else
                    state_d = DIRECT;
`endif
                end
                DIRECT: begin
`ifdef DECODER_NTO2N_SCAN_EN
                    if (mode) begin
                        state_d     = SCAN;
                        div_d       = '0;
                        idx_d       = '0;
                        out_d       = onehot('0);
                        sel_d       = '0;
                        out_valid_d = 1'b1;
                    end else
`endif
                    if (in_valid) begin
                        out_d       = onehot(in);
                        sel_d       = in;
                        out_valid_d = 1'b1;
                    end
                end
`ifdef DECODER_NTO2N_SCAN_EN
                SCAN: begin
                    if (!mode) begin
                        // out and sel hold until the next accepted code
                        state_d = DIRECT;
                        div_d   = '0;
                        idx_d   = '0;
                    end else if (div_q == DIV_TC) begin
                        // Index wraps naturally through the N-bit adder
                        div_d       = '0;
                        idx_d       = idx_q + N'(1);
                        out_d       = onehot(idx_q + N'(1));
                        sel_d       = idx_q + N'(1);
                        out_valid_d = 1'b1;
                    end else begin
                        div_d = div_q + 16'd1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= OUT_INACTIVE;
            out_valid_q <= 1'b0;
            sel_q       <= '0;
`ifdef DECODER_NTO2N_SCAN_EN
            div_q       <= '0;
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
`ifdef DECODER_NTO2N_SCAN_EN
            div_q       <= div_d;
            idx_q       <= idx_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sel       = sel_q;

endmodule
